// File: rtl/rvfi_iss_event_sequencer_if.sv
// rvfi_iss_event_sequencer_if
//   Bundles the RVFI retirement capture signals and the event hand-off
//   signals of the ISS event sequencer.
//   master : sequencer side (consumes RVFI records, sources events)
//   slave  : environment side (drives RVFI records, consumes events)
//   Signals:
//     rvfi_valid_i/order_i/insn_i/pc_i/intr_i, mip_i : retirement capture
//     flush_i                                        : synchronous FIFO clear
//     ev_valid_o/ev_ready_i                          : event handshake
//     ev_kind_o/order_o/insn_o/pc_o/mip_o            : head event payload
//     count_o, overflow_o, order_err_o               : status
interface rvfi_iss_event_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            rvfi_valid_i;
  logic [63:0]     rvfi_order_i;
  logic [ILEN-1:0] rvfi_insn_i;
  logic [XLEN-1:0] rvfi_pc_i;
  logic            rvfi_intr_i;
  logic [XLEN-1:0] mip_i;
  logic            flush_i;
  logic            ev_valid_o;
  logic            ev_ready_i;
  logic            ev_kind_o;
  logic [63:0]     ev_order_o;
  logic [ILEN-1:0] ev_insn_o;
  logic [XLEN-1:0] ev_pc_o;
  logic [XLEN-1:0] ev_mip_o;
  logic [CW-1:0]   count_o;
  logic            overflow_o;
  logic            order_err_o;

  modport master (
    input  rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_pc_i, rvfi_intr_i,
           mip_i, flush_i, ev_ready_i,
    output ev_valid_o, ev_kind_o, ev_order_o, ev_insn_o, ev_pc_o, ev_mip_o,
           count_o, overflow_o, order_err_o
  );

  modport slave (
    output rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_pc_i, rvfi_intr_i,
           mip_i, flush_i, ev_ready_i,
    input  ev_valid_o, ev_kind_o, ev_order_o, ev_insn_o, ev_pc_o, ev_mip_o,
           count_o, overflow_o, order_err_o
  );
endinterface

// File: rtl/rvfi_iss_event_sequencer.sv
// rvfi_iss_event_sequencer
//   Captures RVFI retirements into an in-order event FIFO for the ISS
//   lockstep driver. An interrupt-entry retirement becomes two events: an
//   INTR event carrying the mip snapshot, followed by the STEP event.
//   Ports:
//     clk_i  : clock
//     rst_ni : asynchronous active-low reset
//     bus    : rvfi_iss_event_sequencer_if.master (capture, events, status)
//
// Handshake: ev_valid_o is high whenever the FIFO holds an event; the head
// event is transferred on a cycle where ev_valid_o && ev_ready_i. While
// ev_valid_o && !ev_ready_i the payload is held stable. ev_valid_o does not
// depend on ev_ready_i.
module rvfi_iss_event_sequencer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  rvfi_iss_event_sequencer_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic            r_kind  [DEPTH];
  logic [63:0]     r_order [DEPTH];
  logic [ILEN-1:0] r_insn  [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_mip   [DEPTH];

  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow, r_order_err;
  logic          r_base_vld;
  logic [63:0]   r_base;

  logic [CW-1:0] w_free, w_need;
  logic          w_fit, w_push, w_pop, w_rec;
  logic [1:0]    w_push_n;
  logic [AW-1:0] w_tail1;

  // Retirements arriving in a flush cycle are ignored entirely.
  assign w_rec    = bus.rvfi_valid_i && !bus.flush_i;
  // Room is judged on the registered count only; a same-cycle pop does not help.
  assign w_free   = DEPTH_C - r_count;
  assign w_need   = bus.rvfi_intr_i ? CW'(2) : CW'(1);
  assign w_fit    = (w_free >= w_need);
  assign w_push   = w_rec && w_fit;
  assign w_pop    = (r_count != '0) && bus.ev_ready_i && !bus.flush_i;
  assign w_push_n = !w_push ? 2'd0 : (bus.rvfi_intr_i ? 2'd2 : 2'd1);
  assign w_tail1  = r_tail + AW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_kind[i]  <= 1'b0;
        r_order[i] <= '0;
        r_insn[i]  <= '0;
        r_pc[i]    <= '0;
        r_mip[i]   <= '0;
      end
    end else if (w_push) begin
      if (bus.rvfi_intr_i) begin
        r_kind[r_tail]   <= 1'b1;
        r_order[r_tail]  <= bus.rvfi_order_i;
        r_insn[r_tail]   <= '0;
        r_pc[r_tail]     <= bus.rvfi_pc_i;
        r_mip[r_tail]    <= bus.mip_i;
        r_kind[w_tail1]  <= 1'b0;
        r_order[w_tail1] <= bus.rvfi_order_i;
        r_insn[w_tail1]  <= bus.rvfi_insn_i;
        r_pc[w_tail1]    <= bus.rvfi_pc_i;
        r_mip[w_tail1]   <= '0;
      end else begin
        r_kind[r_tail]   <= 1'b0;
        r_order[r_tail]  <= bus.rvfi_order_i;
        r_insn[r_tail]   <= bus.rvfi_insn_i;
        r_pc[r_tail]     <= bus.rvfi_pc_i;
        r_mip[r_tail]    <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= r_head + AW'(1);
      r_tail  <= r_tail + AW'(w_push_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop);
    end
  end

  // Order baseline tracks every non-flushed retirement, dropped or not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow  <= 1'b0;
      r_order_err <= 1'b0;
      r_base_vld  <= 1'b0;
      r_base      <= '0;
    end else if (bus.flush_i) begin
      r_base_vld  <= 1'b0;
    end else if (w_rec) begin
      if (!w_fit) r_overflow <= 1'b1;
      if (r_base_vld && (bus.rvfi_order_i != r_base + 64'd1)) r_order_err <= 1'b1;
      r_base_vld  <= 1'b1;
      r_base      <= bus.rvfi_order_i;
    end
  end

  assign bus.ev_valid_o  = (r_count != '0);
  assign bus.ev_kind_o   = r_kind[r_head];
  assign bus.ev_order_o  = r_order[r_head];
  assign bus.ev_insn_o   = r_insn[r_head];
  assign bus.ev_pc_o     = r_pc[r_head];
  assign bus.ev_mip_o    = r_mip[r_head];
  assign bus.count_o     = r_count;
  assign bus.overflow_o  = r_overflow;
  assign bus.order_err_o = r_order_err;
endmodule

// File: tb/tb_rvfi_iss_event_sequencer.sv
module tb_rvfi_iss_event_sequencer;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;

  typedef struct {
    logic        kind;
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] mip;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  rvfi_iss_event_sequencer_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) bus ();

  rvfi_iss_event_sequencer #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // ---------------- reference model ----------------
  ev_t         exp_q[$];
  logic        m_overflow, m_order_err, m_base_vld;
  logic [63:0] m_base;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_overflow  = 1'b0;
    m_order_err = 1'b0;
    m_base_vld  = 1'b0;
    m_base      = '0;
  endfunction

  // Advances the model by one clock edge using the currently driven inputs.
  function automatic void model_update();
    ev_t e;
    int  free;
    int  need;
    bit  do_pop;
    if (bus.flush_i) begin
      exp_q.delete();
      m_base_vld = 1'b0;
      return;
    end
    free   = DEPTH - exp_q.size();
    do_pop = (exp_q.size() != 0) && bus.ev_ready_i;
    if (do_pop) void'(exp_q.pop_front());
    if (bus.rvfi_valid_i) begin
      if (m_base_vld && bus.rvfi_order_i != m_base + 1) m_order_err = 1'b1;
      m_base_vld = 1'b1;
      m_base     = bus.rvfi_order_i;
      need = bus.rvfi_intr_i ? 2 : 1;
      if (need > free) m_overflow = 1'b1;
      else begin
        if (bus.rvfi_intr_i) begin
          e = '{kind: 1'b1, order: bus.rvfi_order_i, insn: 32'h0,
                pc: bus.rvfi_pc_i, mip: bus.mip_i};
          exp_q.push_back(e);
        end
        e = '{kind: 1'b0, order: bus.rvfi_order_i, insn: bus.rvfi_insn_i,
              pc: bus.rvfi_pc_i, mip: 32'h0};
        exp_q.push_back(e);
      end
    end
  endfunction

  // ---------------- scoreboard compare ----------------
  function automatic void compare();
    chk("ev_valid", 64'(bus.ev_valid_o), 64'(exp_q.size() != 0));
    chk("count", 64'(bus.count_o), 64'(exp_q.size()));
    chk("overflow", 64'(bus.overflow_o), 64'(m_overflow));
    chk("order_err", 64'(bus.order_err_o), 64'(m_order_err));
    if (exp_q.size() != 0) begin
      chk("ev_kind", 64'(bus.ev_kind_o), 64'(exp_q[0].kind));
      chk("ev_order", bus.ev_order_o, exp_q[0].order);
      chk("ev_insn", 64'(bus.ev_insn_o), 64'(exp_q[0].insn));
      chk("ev_pc", 64'(bus.ev_pc_o), 64'(exp_q[0].pc));
      chk("ev_mip", 64'(bus.ev_mip_o), 64'(exp_q[0].mip));
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_i);
    compare();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input logic [63:0] ord, input logic [31:0] pc,
                       input logic [31:0] insn, input bit intr, input logic [31:0] mip,
                       input bit rdy, input bit fl);
    bus.rvfi_valid_i = v;
    bus.rvfi_order_i = ord;
    bus.rvfi_pc_i    = pc;
    bus.rvfi_insn_i  = insn;
    bus.rvfi_intr_i  = intr;
    bus.mip_i        = mip;
    bus.ev_ready_i   = rdy;
    bus.flush_i      = fl;
    step();
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 64'h0, 32'h0, 32'h0, 1'b0, 32'h0, rdy, 1'b0);
  endtask

  task automatic retire(input logic [63:0] ord, input logic [31:0] pc, input bit intr,
                        input logic [31:0] mip, input bit rdy);
    drive(1'b1, ord, pc, 32'h1300_0000 | 32'(ord), intr, mip, rdy, 1'b0);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    bus.rvfi_valid_i = 1'b0; bus.rvfi_order_i = '0; bus.rvfi_insn_i = '0;
    bus.rvfi_pc_i = '0; bus.rvfi_intr_i = 1'b0; bus.mip_i = '0;
    bus.flush_i = 1'b0; bus.ev_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(bus.ev_valid_o), 64'h0);
    chk("rst_count", 64'(bus.count_o), 64'h0);
    chk("rst_flags", 64'({bus.overflow_o, bus.order_err_o}), 64'h0);
    chk("rst_payload", 64'(bus.ev_kind_o) | bus.ev_order_o | 64'(bus.ev_pc_o)
        | 64'(bus.ev_insn_o) | 64'(bus.ev_mip_o), 64'h0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ord;
    apply_reset();

    // Three plain retirements drained at full rate.
    retire(64'd0, 32'h80, 1'b0, 32'h0, 1'b1);
    chk("t1_first_valid", 64'(bus.ev_valid_o), 64'h1);
    chk("t1_first_pc", 64'(bus.ev_pc_o), 64'h80);
    retire(64'd1, 32'h84, 1'b0, 32'h0, 1'b1);
    retire(64'd2, 32'h88, 1'b0, 32'h0, 1'b1);
    chk("t1_head_pc", 64'(bus.ev_pc_o), 64'h88);
    repeat (3) idle(1'b1);
    chk("t1_order_err", 64'(bus.order_err_o), 64'h0);

    // Interrupt entry yields INTR then STEP.
    apply_reset();
    retire(64'd5, 32'h1000, 1'b1, 32'h80, 1'b0);
    chk("t2_count", 64'(bus.count_o), 64'h2);
    chk("t2_kind", 64'(bus.ev_kind_o), 64'h1);
    chk("t2_mip", 64'(bus.ev_mip_o), 64'h80);
    chk("t2_insn0", 64'(bus.ev_insn_o), 64'h0);
    idle(1'b0);
    idle(1'b1);
    chk("t2_step_kind", 64'(bus.ev_kind_o), 64'h0);
    chk("t2_step_insn", 64'(bus.ev_insn_o), 64'h1300_0005);
    chk("t2_step_mip", 64'(bus.ev_mip_o), 64'h0);
    repeat (2) idle(1'b1);

    // Fill to DEPTH, overflow, oversized intr retirement, full pop+push.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) retire(64'(i), 32'(32'h200 + 4 * i), 1'b0, 32'h0, 1'b0);
    chk("t3_full", 64'(bus.count_o), 64'd8);
    retire(64'd8, 32'h220, 1'b0, 32'h0, 1'b0);
    chk("t3_drop_count", 64'(bus.count_o), 64'd8);
    chk("t3_overflow", 64'(bus.overflow_o), 64'h1);
    idle(1'b1);
    chk("t3_count7", 64'(bus.count_o), 64'd7);
    retire(64'd9, 32'h224, 1'b1, 32'h800, 1'b0);
    chk("t3_intr_drop", 64'(bus.count_o), 64'd7);
    retire(64'd10, 32'h228, 1'b0, 32'h0, 1'b0);
    retire(64'd11, 32'h22c, 1'b0, 32'h0, 1'b1);
    chk("t4_pop_push_full", 64'(bus.count_o), 64'd7);
    repeat (8) idle(1'b1);

    // Order gap flags an error but still delivers.
    apply_reset();
    retire(64'd10, 32'h300, 1'b0, 32'h0, 1'b1);
    retire(64'd11, 32'h304, 1'b0, 32'h0, 1'b1);
    chk("t5_no_err", 64'(bus.order_err_o), 64'h0);
    retire(64'd13, 32'h308, 1'b0, 32'h0, 1'b1);
    chk("t5_err", 64'(bus.order_err_o), 64'h1);
    repeat (3) idle(1'b1);

    // Flush with a concurrent retirement, then an arbitrary order.
    apply_reset();
    for (int i = 0; i < 4; i++) retire(64'(20 + i), 32'(32'h400 + 4 * i), 1'b0, 32'h0, 1'b0);
    drive(1'b1, 64'd24, 32'h410, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_count", 64'(bus.count_o), 64'h0);
    chk("t6_valid", 64'(bus.ev_valid_o), 64'h0);
    retire(64'd99, 32'h500, 1'b0, 32'h0, 1'b0);
    chk("t6_no_err", 64'(bus.order_err_o), 64'h0);
    chk("t6_count1", 64'(bus.count_o), 64'h1);
    repeat (2) idle(1'b1);

    // Randomized traffic.
    ord = 64'd100;
    for (int c = 0; c < 3000; c++) begin
      bit v, intr, rdy, fl;
      v    = ($urandom_range(0, 9) < 6);
      intr = ($urandom_range(0, 9) < 2);
      rdy  = ($urandom_range(0, 9) < 5);
      fl   = ($urandom_range(0, 99) < 2);
      if (v) ord = ($urandom_range(0, 99) < 4) ? ord + 64'($urandom_range(2, 5)) : ord + 64'd1;
      drive(v, ord, $urandom, $urandom, intr, $urandom, rdy, fl);
    end

    // Asynchronous reset mid-operation empties the FIFO immediately.
    for (int i = 0; i < 3; i++) retire(64'(i), 32'h600, 1'b0, 32'h0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.ev_valid_o), 64'h0);
    chk("async_rst_count", 64'(bus.count_o), 64'h0);
    apply_reset();
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rvfi_iss_event_sequencer.md
Name: rvfi_iss_event_sequencer

Overview:
- RTL-side producer feeding the ISS lockstep driver in the testbench.
- Captures retirement records from the core's RVFI port and converts interrupt-entry retirements into a separate INTR event carrying a mip snapshot. The INTR event is queued ahead of the retirement's STEP event.
- Buffers all events in an in-order FIFO and hands them one at a time to the consumer over valid/ready. The consumer applies mip, then steps the ISS.
- Flags overflow and order discontinuities.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, >= 4
- XLEN, 32, pc/mip width
- ILEN, 32, instruction word width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rvfi_valid_i  in  1  retirement this cycle
- rvfi_order_i  in  64  retirement order number
- rvfi_insn_i  in  ILEN  retired instruction
- rvfi_pc_i  in  XLEN  pc of retired instruction
- rvfi_intr_i  in  1  retired instruction is first of an interrupt handler
- mip_i  in  XLEN  core mip CSR value, sampled with rvfi_valid_i
- flush_i  in  1  synchronous FIFO clear
- ev_valid_o  out  1  head event available
- ev_ready_i  in  1  consumer accepts head event
- ev_kind_o  out  1  0=STEP, 1=INTR
- ev_order_o  out  64  order of associated retirement
- ev_insn_o  out  ILEN  instruction (zero for INTR)
- ev_pc_o  out  XLEN  pc of associated retirement
- ev_mip_o  out  XLEN  mip snapshot (INTR only, zero for STEP)
- count_o  out  $clog2(DEPTH)+1  occupied entries
- overflow_o  out  1  sticky: a retirement was dropped
- order_err_o  out  1  sticky: order discontinuity

Behaviour:
Reset (rst_ni low, asynchronous):
- Pointers and count cleared.
- All outputs 0.
- Order baseline invalid.

Push rules:
- rvfi_valid_i=1, rvfi_intr_i=0: needs 1 slot; push STEP.
- rvfi_valid_i=1, rvfi_intr_i=1: needs 2 slots; push INTR {order, pc, mip_i, insn=0} at tail, then STEP {order, insn, pc, mip=0} at tail+1.
- Free space is DEPTH - count as registered at the start of the cycle. A pop in the same cycle does not create room.
- Insufficient space: the whole retirement is dropped (neither event is written) and overflow_o is set.

Pop:
- ev_valid_o = (count != 0).
- Outputs are driven directly from storage at the head pointer; there is no combinational path from the rvfi inputs.
- Pop occurs when ev_valid_o && ev_ready_i.
- Outputs are stable while ev_valid_o && !ev_ready_i.

Latency and count:
- Retirement in cycle N gives ev_valid_o high in cycle N+1 when the FIFO was empty.
- count_o next = count + pushes - pop, where pushes is 0..2 and pop is 0..1.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

Order check:
- First accepted-or-dropped retirement after reset or flush sets the baseline.
- Each later retirement compares rvfi_order_i to baseline+1. Mismatch sets order_err_o, but the record is still pushed.
- The baseline updates to rvfi_order_i on every valid retirement, including dropped ones.

Flush (flush_i=1):
- Count and pointers zeroed and order baseline invalidated at the next edge.
- A pop or push in the same cycle is ignored.
- Sticky flags are kept; only rst_ni clears them.

Reset mid-operation:
- Immediately empties the FIFO; ev_valid_o drops asynchronously.

Test Plan:
1. Reset, then 3 retirements (orders 0, 1, 2; pc 0x80, 0x84, 0x88) with ev_ready_i=1 -> 3 STEP events in order, first ev_valid_o one cycle after first retirement, order_err_o=0.
2. Retirement order 5, pc 0x1000, rvfi_intr_i=1, mip_i=0x80, ev_ready_i=0 -> count_o=2; head INTR {order 5, pc 0x1000, mip 0x80}; after one pop, STEP {order 5, insn given}.
3. ev_ready_i=0, 8 plain retirements fill DEPTH=8 -> count_o=8; 9th retirement dropped, overflow_o=1; with count=7 an intr retirement is dropped entirely (count stays 7).
4. Full FIFO, simultaneous pop and retirement -> retirement dropped, count_o=7, overflow_o=1.
5. Orders 10, 11, 13 -> order_err_o=1 after order 13 arrives; all 3 events still delivered.
6. 4 events queued, flush_i=1 together with a retirement -> count_o=0, ev_valid_o=0 next cycle, overflow_o and order_err_o unchanged; next retirement (any order) raises no order_err.
